// File: rtl/midi_voice_pkg.sv
// Shared definitions for the MIDI voice allocator: FSM encoding, MIDI field widths, index sizing.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package midi_voice_pkg;

  localparam int MIDI_NOTE_BITS = 7;
  localparam int MIDI_VEL_BITS  = 7;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SCAN   = 2'd1,
    ST_APPLY  = 2'd2,
    ST_REGATE = 2'd3
  } voice_state_t;

  // Bits needed to index (and rank) n voices; never less than one.
  function automatic int idx_bits(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/midi_voice_lru.sv
// LRU rank tracker: rank 0 is most recently allocated, NUM_VOICES-1 is the steal candidate.
// Latency: ranks update on the edge where touch is high; oldest_idx is combinational from ranks.
// Backpressure: none; touch is honoured every cycle it is asserted.
module midi_voice_lru
  import midi_voice_pkg::*;
#(
  parameter int NUM_VOICES = 4,
  localparam int IW = idx_bits(NUM_VOICES)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     touch,
  input  logic [IW-1:0]            touch_idx,
  output logic [NUM_VOICES*IW-1:0] ranks,
  output logic [IW-1:0]            oldest_idx
);

  logic [IW-1:0] rank_q [NUM_VOICES];
  logic [IW-1:0] touched_rank;

  assign touched_rank = rank_q[touch_idx];

  // Move the touched voice to rank 0 and age every voice that was younger than it.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_VOICES; i++) begin
        rank_q[i] <= IW'(i);
      end
    end else if (touch) begin
      for (int i = 0; i < NUM_VOICES; i++) begin
        if (IW'(i) == touch_idx) begin
          rank_q[i] <= '0;
        end else if (rank_q[i] < touched_rank) begin
          rank_q[i] <= rank_q[i] + 1'b1;
        end
      end
    end
  end

  // Flatten ranks and locate the voice holding the highest rank.
  always_comb begin
    ranks      = '0;
    oldest_idx = '0;
    for (int i = 0; i < NUM_VOICES; i++) begin
      ranks[i*IW +: IW] = rank_q[i];
      if (rank_q[i] == IW'(NUM_VOICES - 1)) begin
        oldest_idx = IW'(i);
      end
    end
  end

endmodule

// File: rtl/midi_voice_allocator.sv
// Polyphonic voice allocator: retrigger on match, else lowest free voice, else steal the oldest.
// Latency: accept t, SCAN t+1..t+N, APPLY t+N+1 (outputs visible), optional REGATE t+N+2.
// Backpressure: ev_ready only in IDLE; one event in flight, all_off aborts it and forces IDLE.
module midi_voice_allocator
  import midi_voice_pkg::*;
#(
  parameter int NUM_VOICES = 4
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                ev_valid,
  output logic                                ev_ready,
  input  logic                                ev_note_on,
  input  logic [MIDI_NOTE_BITS-1:0]           ev_note,
  input  logic [MIDI_VEL_BITS-1:0]            ev_vel,
  input  logic                                all_off,
  output logic [NUM_VOICES-1:0]               voice_gate,
  output logic [MIDI_NOTE_BITS*NUM_VOICES-1:0] voice_note,
  output logic [MIDI_VEL_BITS*NUM_VOICES-1:0]  voice_vel,
  output logic                                busy
);

  localparam int            IW       = idx_bits(NUM_VOICES);
  localparam logic [IW-1:0] LAST_IDX = IW'(NUM_VOICES - 1);

  voice_state_t state, state_nxt;

  // Latched event
  logic                      ev_on_r;
  logic [MIDI_NOTE_BITS-1:0] ev_note_r;
  logic [MIDI_VEL_BITS-1:0]  ev_vel_r;

  // Scan results accumulated over the SCAN cycles
  logic [IW-1:0]         scan_idx;
  logic                  match_found, free_found, oldest_found;
  logic [IW-1:0]         match_idx, free_idx, oldest_r;
  logic [NUM_VOICES-1:0] match_mask;
  logic                  regate_pend;
  logic [IW-1:0]         regate_idx;

  // Voice state
  logic [NUM_VOICES-1:0]     gate_q;
  logic [MIDI_NOTE_BITS-1:0] note_q [NUM_VOICES];
  logic [MIDI_VEL_BITS-1:0]  vel_q  [NUM_VOICES];

  logic [NUM_VOICES*IW-1:0] ranks;
  logic [IW-1:0]            oldest_idx;

  logic                  accept, scan_last, apply_now;
  logic                  cur_gate, cur_match, cur_oldest;
  logic                  fin_match_found, fin_free_found, fin_oldest_found;
  logic [IW-1:0]         fin_match_idx, fin_free_idx, fin_oldest_idx;
  logic [NUM_VOICES-1:0] fin_mask, cur_onehot;
  logic [IW-1:0]         tgt_idx;
  logic                  tgt_regate;

  assign accept    = ev_valid && ev_ready;
  assign scan_last = (state == ST_SCAN) && (scan_idx == LAST_IDX);
  assign apply_now = scan_last && !all_off;

  // One comparator walks the voices; the last SCAN cycle folds its result in directly.
  assign cur_gate   = gate_q[scan_idx];
  assign cur_match  = cur_gate && (note_q[scan_idx] == ev_note_r);
  assign cur_oldest = (ranks[scan_idx*IW +: IW] == LAST_IDX);
  assign cur_onehot = NUM_VOICES'(1) << scan_idx;

  assign fin_match_found  = match_found || cur_match;
  assign fin_match_idx    = match_found ? match_idx : scan_idx;
  assign fin_free_found   = free_found || !cur_gate;
  assign fin_free_idx     = free_found ? free_idx : scan_idx;
  assign fin_oldest_found = oldest_found || cur_oldest;
  assign fin_oldest_idx   = oldest_found ? oldest_r : scan_idx;
  assign fin_mask         = match_mask | (cur_match ? cur_onehot : '0);

  // Pick the target voice for a note-on: retrigger, then free, then steal.
  always_comb begin
    tgt_idx    = oldest_idx;
    tgt_regate = 1'b1;
    if (fin_match_found) begin
      tgt_idx = fin_match_idx;
    end else if (fin_free_found) begin
      tgt_idx    = fin_free_idx;
      tgt_regate = 1'b0;
    end else if (fin_oldest_found) begin
      tgt_idx = fin_oldest_idx;
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic; all_off overrides any transition.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:   if (accept) state_nxt = ST_SCAN;
      ST_SCAN:   if (scan_last) state_nxt = ST_APPLY;
      ST_APPLY:  state_nxt = regate_pend ? ST_REGATE : ST_IDLE;
      ST_REGATE: state_nxt = ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
    if (all_off) state_nxt = ST_IDLE;
  end

  // FSM outputs.
  always_comb begin
    ev_ready = (state == ST_IDLE) && !rst;
    busy     = (state != ST_IDLE);
  end

  // Latch the event on accept and accumulate scan results one voice per cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      ev_on_r      <= 1'b0;
      ev_note_r    <= '0;
      ev_vel_r     <= '0;
      scan_idx     <= '0;
      match_found  <= 1'b0;
      free_found   <= 1'b0;
      oldest_found <= 1'b0;
      match_idx    <= '0;
      free_idx     <= '0;
      oldest_r     <= '0;
      match_mask   <= '0;
      regate_pend  <= 1'b0;
      regate_idx   <= '0;
    end else begin
      if (accept && !all_off) begin
        ev_on_r      <= ev_note_on && (ev_vel != '0);
        ev_note_r    <= ev_note;
        ev_vel_r     <= ev_vel;
        scan_idx     <= '0;
        match_found  <= 1'b0;
        free_found   <= 1'b0;
        oldest_found <= 1'b0;
        match_mask   <= '0;
      end else if (state == ST_SCAN) begin
        scan_idx     <= scan_idx + 1'b1;
        match_found  <= fin_match_found;
        match_idx    <= fin_match_idx;
        free_found   <= fin_free_found;
        free_idx     <= fin_free_idx;
        oldest_found <= fin_oldest_found;
        oldest_r     <= fin_oldest_idx;
        match_mask   <= fin_mask;
      end
      if (scan_last) begin
        regate_pend <= ev_on_r && tgt_regate;
        regate_idx  <= tgt_idx;
      end
    end
  end

  // Voice gates, notes and velocities; notes/vels only change on a load so release keeps pitch.
  always_ff @(posedge clk) begin
    if (rst) begin
      gate_q <= '0;
      for (int i = 0; i < NUM_VOICES; i++) begin
        note_q[i] <= '0;
        vel_q[i]  <= '0;
      end
    end else if (all_off) begin
      gate_q <= '0;
    end else if (apply_now) begin
      if (ev_on_r) begin
        gate_q[tgt_idx] <= !tgt_regate;
        note_q[tgt_idx] <= ev_note_r;
        vel_q[tgt_idx]  <= ev_vel_r;
      end else begin
        gate_q <= gate_q & ~fin_mask;
      end
    end else if ((state == ST_APPLY) && regate_pend) begin
      gate_q[regate_idx] <= 1'b1;
    end
  end

  midi_voice_lru #(
    .NUM_VOICES (NUM_VOICES)
  ) u_lru (
    .clk        (clk),
    .rst        (rst),
    .touch      (apply_now && ev_on_r),
    .touch_idx  (tgt_idx),
    .ranks      (ranks),
    .oldest_idx (oldest_idx)
  );

  // Pack per-voice registers onto the output buses.
  always_comb begin
    voice_gate = gate_q;
    voice_note = '0;
    voice_vel  = '0;
    for (int i = 0; i < NUM_VOICES; i++) begin
      voice_note[i*MIDI_NOTE_BITS +: MIDI_NOTE_BITS] = note_q[i];
      voice_vel[i*MIDI_VEL_BITS +: MIDI_VEL_BITS]    = vel_q[i];
    end
  end

endmodule

// File: tb/tb_midi_voice_allocator.sv
// Bench for midi_voice_allocator: directed scenarios with literal expectations plus random traffic.
// Latency: n/a.
// Backpressure: events are held until ev_ready is seen.
module tb_midi_voice_allocator;

  localparam int NV = 4;

  logic            clk = 1'b0;
  logic            rst, ev_valid, ev_note_on, all_off;
  logic [6:0]      ev_note, ev_vel;
  logic            ev_ready, busy;
  logic [NV-1:0]   voice_gate;
  logic [7*NV-1:0] voice_note, voice_vel;

  int errors = 0;
  int checks = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  midi_voice_allocator #(.NUM_VOICES(NV)) dut (
    .clk        (clk),
    .rst        (rst),
    .ev_valid   (ev_valid),
    .ev_ready   (ev_ready),
    .ev_note_on (ev_note_on),
    .ev_note    (ev_note),
    .ev_vel     (ev_vel),
    .all_off    (all_off),
    .voice_gate (voice_gate),
    .voice_note (voice_note),
    .voice_vel  (voice_vel),
    .busy       (busy)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  bit m_gate [NV];
  int m_note [NV];
  int m_vel  [NV];
  int m_rank [NV];
  bit m_pend, m_on, m_regate;
  int m_age, m_n, m_v, m_tgt;

  task automatic model_apply();
    int v;
    int r;
    v = -1;
    m_regate = 1'b0;
    if (m_on) begin
      for (int i = 0; i < NV; i++) if (v < 0 && m_gate[i] && m_note[i] == m_n) v = i;
      if (v >= 0) m_regate = 1'b1;
      else begin
        for (int i = 0; i < NV; i++) if (v < 0 && !m_gate[i]) v = i;
        if (v < 0) begin
          for (int i = 0; i < NV; i++) if (m_rank[i] == NV - 1) v = i;
          m_regate = 1'b1;
        end
      end
      m_note[v] = m_n;
      m_vel[v]  = m_v;
      m_gate[v] = !m_regate;
      r = m_rank[v];
      for (int j = 0; j < NV; j++) if (m_rank[j] < r) m_rank[j]++;
      m_rank[v] = 0;
      m_tgt = v;
    end else begin
      for (int i = 0; i < NV; i++) if (m_gate[i] && m_note[i] == m_n) m_gate[i] = 1'b0;
    end
  endtask

  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NV; i++) begin
        m_gate[i] = 1'b0; m_note[i] = 0; m_vel[i] = 0; m_rank[i] = i;
      end
      m_pend = 1'b0;
    end else if (all_off) begin
      for (int i = 0; i < NV; i++) m_gate[i] = 1'b0;
      m_pend = 1'b0;
    end else if (m_pend) begin
      m_age++;
      if (m_age == NV) model_apply();
      else if (m_age == NV + 1) begin
        if (m_regate) m_gate[m_tgt] = 1'b1;
        else m_pend = 1'b0;
      end else if (m_age >= NV + 2) m_pend = 1'b0;
    end else if (ev_valid) begin
      m_pend = 1'b1;
      m_age  = 0;
      m_on   = ev_note_on && (ev_vel != 7'd0);
      m_n    = int'(ev_note);
      m_v    = int'(ev_vel);
    end
  end

  // ---------------- per-cycle compare ----------------
  logic [NV-1:0]   e_gate;
  logic [7*NV-1:0] e_note, e_vel;
  logic [2*NV-1:0] e_rank;

  always @(negedge clk) begin
    if (chk_en) begin
      for (int i = 0; i < NV; i++) begin
        e_gate[i]         = m_gate[i];
        e_note[7*i +: 7]  = 7'(m_note[i]);
        e_vel[7*i +: 7]   = 7'(m_vel[i]);
        e_rank[2*i +: 2]  = 2'(m_rank[i]);
      end
      chk("model ev_ready", 32'(ev_ready), 32'(!m_pend && !rst));
      chk("model busy", 32'(busy), 32'(m_pend));
      chk("model voice_gate", 32'(voice_gate), 32'(e_gate));
      chk("model voice_note", 32'(voice_note), 32'(e_note));
      chk("model voice_vel", 32'(voice_vel), 32'(e_vel));
      chk("model ranks", 32'(dut.ranks), 32'(e_rank));
    end
  end

  // ---------------- stimulus helpers (called at posedge+1) ----------------
  task automatic send(input bit on, input int n, input int v);
    int  waited;
    bit  got;
    waited = 0;
    got = 1'b0;
    ev_valid = 1'b1; ev_note_on = on; ev_note = 7'(n); ev_vel = 7'(v);
    while (!got && waited < 40) begin
      @(negedge clk);
      if (ev_ready) got = 1'b1;
      @(posedge clk);
      waited++;
    end
    #1 ev_valid = 1'b0;
    if (!got) begin
      checks++; errors++;
      $display("FAIL send timeout: ev_ready never high for note %0d", n);
    end
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (!(ev_ready && !busy) && n < 30) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 30) begin
      checks++; errors++;
      $display("FAIL idle timeout: busy=%0b ready=%0b", busy, ev_ready);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1; ev_valid = 1'b0; all_off = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic fill4();
    send(1'b1, 60, 100); wait_idle();
    send(1'b1, 62, 101); wait_idle();
    send(1'b1, 64, 102); wait_idle();
    send(1'b1, 65, 103); wait_idle();
  endtask

  initial begin
    rst = 1'b1; ev_valid = 1'b0; ev_note_on = 1'b0; ev_note = '0; ev_vel = '0; all_off = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    chk_en = 1'b1;

    // A: reset values, then single note-on latency
    @(negedge clk);
    chk("A reset ready", 32'(ev_ready), 32'd1);
    chk("A reset busy", 32'(busy), 32'd0);
    chk("A reset gate", 32'(voice_gate), 32'd0);
    chk("A reset note", 32'(voice_note), 32'd0);
    chk("A reset vel", 32'(voice_vel), 32'd0);
    chk("A reset ranks", 32'(dut.ranks), 32'hE4);
    @(posedge clk); #1;
    send(1'b1, 60, 100);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("A gate before apply", 32'(voice_gate), 32'd0);
    @(posedge clk); @(negedge clk);
    chk("A gate at apply", 32'(voice_gate), 32'd1);
    chk("A note0", 32'(voice_note[6:0]), 32'd60);
    chk("A vel0", 32'(voice_vel[6:0]), 32'd100);
    chk("A ready in apply", 32'(ev_ready), 32'd0);
    @(posedge clk); @(negedge clk);
    chk("A ready after apply", 32'(ev_ready), 32'd1);
    @(posedge clk); #1;

    // B: fill four voices then steal voice 0
    do_reset();
    fill4();
    @(negedge clk);
    chk("B gates full", 32'(voice_gate), 32'hF);
    chk("B notes", 32'(voice_note), 32'({7'd65, 7'd64, 7'd62, 7'd60}));
    chk("B ranks", 32'(dut.ranks), 32'h1B);
    @(posedge clk); #1;
    send(1'b1, 67, 80);
    repeat (4) @(posedge clk);
    @(negedge clk);
    chk("B steal gate dip", 32'(voice_gate), 32'hE);
    chk("B steal note0", 32'(voice_note[6:0]), 32'd67);
    @(posedge clk); @(negedge clk);
    chk("B regate gate", 32'(voice_gate), 32'hF);
    chk("B regate ready", 32'(ev_ready), 32'd0);
    @(posedge clk); @(negedge clk);
    chk("B ready after regate", 32'(ev_ready), 32'd1);
    chk("B ranks after steal", 32'(dut.ranks), 32'h6C);
    @(posedge clk); #1;

    // C: same note twice retriggers voice 0
    do_reset();
    send(1'b1, 60, 100); wait_idle();
    send(1'b1, 60, 90);
    repeat (4) @(posedge clk);
    @(negedge clk);
    chk("C retrig dip", 32'(voice_gate), 32'd0);
    @(posedge clk); @(negedge clk);
    chk("C retrig gate", 32'(voice_gate), 32'd1);
    chk("C retrig vel0", 32'(voice_vel[6:0]), 32'd90);
    @(posedge clk); #1;
    wait_idle();

    // D: unmatched note-off is a no-op, vel=0 note-on releases
    do_reset();
    send(1'b1, 60, 100); wait_idle();
    send(1'b0, 61, 50); wait_idle();
    @(negedge clk);
    chk("D off61 gate", 32'(voice_gate), 32'd1);
    chk("D off61 note", 32'(voice_note), 32'd60);
    @(posedge clk); #1;
    send(1'b1, 60, 0); wait_idle();
    @(negedge clk);
    chk("D vel0 gate", 32'(voice_gate), 32'd0);
    chk("D vel0 note kept", 32'(voice_note[6:0]), 32'd60);
    chk("D vel0 vel kept", 32'(voice_vel[6:0]), 32'd100);
    @(posedge clk); #1;

    // E: all_off during SCAN with three gates high
    do_reset();
    send(1'b1, 60, 100); wait_idle();
    send(1'b1, 62, 100); wait_idle();
    send(1'b1, 64, 100); wait_idle();
    @(negedge clk);
    chk("E three gates", 32'(voice_gate), 32'h7);
    @(posedge clk); #1;
    send(1'b1, 65, 70);
    @(posedge clk); #1 all_off = 1'b1;
    @(posedge clk); #1 all_off = 1'b0;
    @(negedge clk);
    chk("E alloff gates", 32'(voice_gate), 32'd0);
    chk("E alloff ready", 32'(ev_ready), 32'd1);
    chk("E alloff busy", 32'(busy), 32'd0);
    repeat (8) @(posedge clk);
    @(negedge clk);
    chk("E event lost note3", 32'(voice_note[27:21]), 32'd0);
    chk("E note0 kept", 32'(voice_note[6:0]), 32'd60);
    chk("E gates stay off", 32'(voice_gate), 32'd0);
    @(posedge clk); #1;

    // F: reset pulsed during REGATE
    do_reset();
    fill4();
    send(1'b1, 67, 80);
    repeat (5) @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    chk("F in regate busy", 32'(busy), 32'd1);
    chk("F ready low in rst", 32'(ev_ready), 32'd0);
    @(posedge clk); @(negedge clk);
    chk("F rst gate", 32'(voice_gate), 32'd0);
    chk("F rst note", 32'(voice_note), 32'd0);
    chk("F rst vel", 32'(voice_vel), 32'd0);
    chk("F rst busy", 32'(busy), 32'd0);
    chk("F rst ranks", 32'(dut.ranks), 32'hE4);
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("F ready after rst", 32'(ev_ready), 32'd1);
    @(posedge clk); #1;

    // Random traffic checked cycle by cycle against the model
    for (int c = 0; c < 3000; c++) begin
      ev_valid   = ($urandom_range(0, 1) == 1);
      ev_note_on = ($urandom_range(0, 3) != 0);
      ev_note    = 7'(60 + $urandom_range(0, 5));
      ev_vel     = ($urandom_range(0, 7) == 0) ? 7'd0 : 7'($urandom_range(1, 127));
      all_off    = ($urandom_range(0, 99) == 0);
      rst        = ($urandom_range(0, 299) == 0);
      @(posedge clk); #1;
    end
    ev_valid = 1'b0; all_off = 1'b0; rst = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk);
    chk_en = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/midi_voice_allocator.md
MIDI_VOICE_ALLOCATOR -- requirements
Module: midi_voice_allocator

Interface
REQ-001 SHALL have parameter NUM_VOICES, default 4, number of synth voices scheduled (2..8).
REQ-002 SHALL have port clk  input  1  system clock, the synth clock that also drives the DAC.
REQ-003 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-004 SHALL have port ev_valid  input  1  MIDI note event offered by the decoder.
REQ-005 SHALL have port ev_ready  output  1  allocator accepts the event this cycle.
REQ-006 SHALL have port ev_note_on  input  1  1 = note-on, 0 = note-off.
REQ-007 SHALL have port ev_note  input  7  MIDI note number.
REQ-008 SHALL have port ev_vel  input  7  MIDI velocity.
REQ-009 SHALL have port all_off  input  1  all-notes-off pulse (CC123/panic).
REQ-010 SHALL have port voice_gate  output  NUM_VOICES  per-voice envelope gate.
REQ-011 SHALL have port voice_note  output  7*NUM_VOICES  per-voice note; voice i occupies bits [7i+6:7i].
REQ-012 SHALL have port voice_vel  output  7*NUM_VOICES  per-voice velocity; same packing as voice_note.
REQ-013 SHALL have port busy  output  1  high whenever the state is not IDLE.

Function
REQ-014 SHALL assert ev_ready only in IDLE; an event is accepted on a cycle where ev_valid and ev_ready are both high.
REQ-015 SHALL treat a note-on with ev_vel == 0 as a note-off.
REQ-016 SHALL implement states IDLE, SCAN, APPLY and REGATE: IDLE->SCAN on accept, SCAN->APPLY after NUM_VOICES cycles, APPLY->REGATE for a retrigger or steal, otherwise APPLY->IDLE, and REGATE->IDLE.
REQ-017 SHALL, in SCAN, examine one voice per cycle (index 0..NUM_VOICES-1), recording the lowest-index active match (gate=1 and note equal), the lowest-index free voice (gate=0), the match mask, and the voice whose LRU rank is NUM_VOICES-1.
REQ-018 SHALL, for a note-on with a match, retrigger the matched voice, so a note held on two voices is never created.
REQ-019 SHALL, for a note-on with no match, allocate the lowest-index free voice: gate rises in APPLY with note and velocity loaded that same cycle.
REQ-020 SHALL, for a note-on with no match and no free voice, steal the rank NUM_VOICES-1 (least recently allocated) voice.
REQ-021 SHALL, on retrigger or steal, drop the gate low in APPLY, load the new note and velocity in APPLY, and raise the gate in REGATE, giving exactly one gate-low cycle.
REQ-022 SHALL, for a note-off, clear the gate of every voice in the match mask in APPLY; with no match it SHALL change nothing.
REQ-023 SHALL hold voice_note and voice_vel unchanged while the gate is low, so the release phase keeps its pitch.
REQ-024 SHALL maintain LRU ranks as a permutation of 0..NUM_VOICES-1: on any note-on allocation to voice v, ranks below rank[v] increment and rank[v] becomes 0; note-offs do not change ranks.
REQ-025 SHALL meet this latency: accept at cycle t, SCAN t+1..t+N, APPLY t+N+1, optional REGATE t+N+2, and ev_ready high again the following cycle.
REQ-026 SHALL, on all_off, clear all gates on the next edge, discard any in-flight event, force IDLE, and retain notes, velocities and ranks.
REQ-027 SHALL give all_off priority over an accept or an APPLY occurring in the same cycle.
REQ-028 SHALL give rst priority over all_off.

Reset
REQ-029 SHALL, on rst, set voice_gate=0, voice_note=0, voice_vel=0, rank[i]=i, state=IDLE, busy=0, and clear all scan registers.
REQ-030 SHALL hold ev_ready low while rst is high and raise it on the first cycle after rst falls.
REQ-031 SHALL, on rst mid-operation, abandon the event, which produces no output change after reset.

Structure
REQ-032 SHALL place the state encoding, MIDI_NOTE_BITS=7 and MIDI_VEL_BITS=7 in the shared package midi_voice_pkg.
REQ-033 SHALL implement the LRU rank tracker as sub-module midi_voice_lru with inputs touch and touch_idx and outputs per-voice ranks and oldest_idx.
REQ-034 SHALL keep the scan sequential, one comparator reused across voices, so area scales only with register count.

Verification (NUM_VOICES=4)
REQ-035 SHALL cover: note-on 60/100 after reset -> voice 0 gate=1, note=60, vel=100 at accept+5; ev_ready back at accept+6.
REQ-036 SHALL cover: note-ons 60, 62, 64, 65, 67 -> voices 0-3 filled; 67 steals voice 0 with gate low exactly 1 cycle and then note=67.
REQ-037 SHALL cover: note-on 60 twice -> the second retriggers voice 0 (1-cycle gate dip) and voices 1-3 stay idle.
REQ-038 SHALL cover: note-on 60 then note-on 60 with vel=0 -> voice 0 gate=0 and note still 60; a note-off 61 changes nothing.
REQ-039 SHALL cover: all_off asserted during SCAN with 3 gates high -> all gates 0 next cycle, the event lost, and IDLE.
REQ-040 SHALL cover: rst pulsed in REGATE -> all outputs return to reset values and ranks read 0,1,2,3.
